vend_dispense_ctrl: RTL

- Sequences the three-lane soda dispense mechanism downstream of the coin-accumulation logic.
- Once payment reaches the vend price, it waits for a single valid selection and checks per-lane stock.
- It then drives exactly one lane output (A_o/B_o/C_o) for a fixed tick count, inhibiting coin acceptance meanwhile.
- It owns the per-lane inventory counters and sold-out flags.

---
 rtl/vend_dispense_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl
//
// Purpose:
//   Dispense sequencer for a three-lane soda machine. After the coin logic
//   reports sufficient credit, it waits for a single valid lane selection,
//   checks that lane's stock, then drives exactly one lane output for
//   VEND_TICKS cycles while inhibiting coin acceptance. It also owns the
//   per-lane stock counters and sold-out flags.
//
// Optional feature (macro VEND_TIMEOUT_EN):
//   When defined, WAIT_SEL gives up after SEL_TIMEOUT cycles without an
//   in-stock valid selection. It returns to IDLE, pulses credit_clr (the
//   credit is forfeited) and pulses the extra output sel_timeout.
//   When undefined, WAIT_SEL waits indefinitely and sel_timeout is absent.
//
// Ports:
//   clk          in   system clock (100 Hz), rising edge
//   rst          in   synchronous active-high reset
//   credit_ok    in   1-cycle pulse: accumulated credit reached vend price
//   A, B, C      in   lane selection buttons (level, already synchronised)
//   refill[2:0]  in   per-lane refill strobes (bit0=A, bit1=B, bit2=C)
//   A_o/B_o/C_o  out  lane dispense drives
//   coin_inhibit out  high while coins must be rejected
//   credit_clr   out  1-cycle pulse: coin logic clears credit
//   sold_out[2:0]out  per-lane stock==0 flags
//   sel_reject   out  1-cycle pulse: a sold-out lane was selected
//   busy         out  high in any state other than IDLE
//   sel_timeout  out  (VEND_TIMEOUT_EN only) 1-cycle selection-timeout pulse
//
// Every output is a register.
// ---------------------------------------------------------------------------
module vend_dispense_ctrl #(
  parameter int VEND_TICKS  = 100,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 10,
  parameter int SEL_TIMEOUT = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       credit_ok,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic [2:0] refill,
  output logic       A_o,
  output logic       B_o,
  output logic       C_o,
  output logic       coin_inhibit,
  output logic       credit_clr,
  output logic [2:0] sold_out,
  output logic       sel_reject,
  output logic       busy
`ifdef VEND_TIMEOUT_EN
  ,
  output logic       sel_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SEL = 2'd1,
    ST_VEND     = 2'd2
  } state_t;

  localparam int                  TICK_W     = 10;
  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(VEND_TICKS - 1);
  localparam logic [STOCK_W-1:0]  STOCK_LOAD = STOCK_W'(STOCK_INIT);

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [TICK_W-1:0]         tick_r;
  logic [TICK_W-1:0]         tick_nxt_s;
  logic [2:0]                lane_r;        // one-hot latched lane
  logic [2:0]                lane_nxt_s;
  logic [2:0][STOCK_W-1:0]   stock_r;
  logic [2:0][STOCK_W-1:0]   stock_nxt_s;
  logic [2:0]                dec_s;         // one-hot lane decrement request
  logic [2:0]                sel_s;
  logic                      sel_one_s;
  logic                      sel_in_stock_s;
  logic                      clr_nxt_s;
  logic                      rej_nxt_s;

`ifdef VEND_TIMEOUT_EN
  localparam int                  DWELL_W    = $clog2(SEL_TIMEOUT + 1);
  localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(SEL_TIMEOUT - 1);

  logic [DWELL_W-1:0]        dwell_r;
  logic                      tmo_nxt_s;
`endif

  // Selection decode: valid only when exactly one button is pressed.
  always_comb begin
    sel_s          = {C, B, A};
    sel_one_s      = (sel_s == 3'b001) || (sel_s == 3'b010) || (sel_s == 3'b100);
    // sold_out mirrors stock==0 for the current cycle, so it doubles as the stock test.
    sel_in_stock_s = sel_one_s && ((sel_s & sold_out) == 3'b000);
  end

  // Next-state, tick, lane latch and pulse decisions.
  always_comb begin
    state_nxt_s = state_r;
    tick_nxt_s  = tick_r;
    lane_nxt_s  = lane_r;
    dec_s       = 3'b000;
    clr_nxt_s   = 1'b0;
    rej_nxt_s   = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_nxt_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (credit_ok) begin
          state_nxt_s = ST_WAIT_SEL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_SEL: begin
        if (sel_in_stock_s) begin
          state_nxt_s = ST_VEND;
          lane_nxt_s  = sel_s;
          dec_s       = sel_s;
          clr_nxt_s   = 1'b1;
          tick_nxt_s  = {TICK_W{1'b0}};
        end else begin
          // A single press of an empty lane is rejected; credit is kept.
          rej_nxt_s = sel_one_s;
`ifdef VEND_TIMEOUT_EN
          if (dwell_r == DWELL_LAST) begin
            state_nxt_s = ST_IDLE;
            clr_nxt_s   = 1'b1;
            tmo_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT_SEL;
          end
`endif
        end
      end
      ST_VEND: begin
        if (tick_r == TICK_LAST) begin
          state_nxt_s = ST_IDLE;
          lane_nxt_s  = 3'b000;
        end else begin
          tick_nxt_s  = tick_r + 10'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        lane_nxt_s  = 3'b000;
        tick_nxt_s  = {TICK_W{1'b0}};
      end
    endcase
  end

  // Per-lane stock update; a refill takes priority over a same-cycle decrement.
  always_comb begin
    stock_nxt_s = stock_r;
    for (int i = 0; i < 3; i++) begin
      if (refill[i]) begin
        stock_nxt_s[i] = STOCK_LOAD;
      end else if (dec_s[i]) begin
        stock_nxt_s[i] = stock_r[i] - {{(STOCK_W-1){1'b0}}, 1'b1};
      end else begin
        stock_nxt_s[i] = stock_r[i];
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tick_r       <= {TICK_W{1'b0}};
      lane_r       <= 3'b000;
      stock_r      <= {3{STOCK_LOAD}};
      sold_out     <= 3'b000;
      A_o          <= 1'b0;
      B_o          <= 1'b0;
      C_o          <= 1'b0;
      coin_inhibit <= 1'b0;
      credit_clr   <= 1'b0;
      sel_reject   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      tick_r       <= tick_nxt_s;
      lane_r       <= lane_nxt_s;
      stock_r      <= stock_nxt_s;
      for (int i = 0; i < 3; i++) begin
        sold_out[i] <= (stock_nxt_s[i] == {STOCK_W{1'b0}});
      end
      // Lane drive follows the next state so it rises/falls on the transition edge.
      A_o          <= (state_nxt_s == ST_VEND) && lane_nxt_s[0];
      B_o          <= (state_nxt_s == ST_VEND) && lane_nxt_s[1];
      C_o          <= (state_nxt_s == ST_VEND) && lane_nxt_s[2];
      coin_inhibit <= (state_nxt_s != ST_IDLE);
      busy         <= (state_nxt_s != ST_IDLE);
      credit_clr   <= clr_nxt_s;
      sel_reject   <= rej_nxt_s;
    end
  end

`ifdef VEND_TIMEOUT_EN
  // WAIT_SEL dwell counter: zero on entry, counts every WAIT_SEL cycle (rejects included).
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_r     <= {DWELL_W{1'b0}};
      sel_timeout <= 1'b0;
    end else begin
      sel_timeout <= tmo_nxt_s;
      if (state_r == ST_WAIT_SEL) begin
        dwell_r <= dwell_r + {{(DWELL_W-1){1'b0}}, 1'b1};
      end else begin
        dwell_r <= {DWELL_W{1'b0}};
      end
    end
  end
`endif

endmodule
